// File: rtl/cnt_seg7_pkg.sv
// Shared types and constants for the two-digit seven-segment scan display.
// Segment patterns are active-low, ordered gfedcba.
package cnt_seg7_pkg;

    typedef enum logic [1:0] {
        BLANK0,
        DIG0,
        BLANK1,
        DIG1
    } scan_state_t;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern decoder.
// Non-decimal codes produce a dark digit.
module seg7_decode
    import cnt_seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/cnt_seg7_scan.sv
// Samples a slow 4-bit counter, accepts stable values and scans them onto a
// 2-digit common-anode display. Define CNT_SEG7_LZ_BLANK_EN to darken a zero tens digit.
module cnt_seg7_scan
    import cnt_seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       re,
    input  logic [3:0] cnt_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [3:0] val,
    output logic       upd
);

    localparam int MAX_LEN = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    // Keep at least one bit so single-cycle phases still elaborate.
    localparam int PC_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [PC_W-1:0] DIG_LAST   = PC_W'(DIGIT_CYCLES - 1);
    localparam logic [PC_W-1:0] BLANK_LAST = PC_W'(BLANK_CYCLES - 1);

    logic [3:0]      s1, s2, s3;
    scan_state_t     state;
    logic [PC_W-1:0] pc;
    logic            tens;
    logic [3:0]      ones;
    logic [6:0]      ones_seg, tens_seg;
    logic            phase_done;

    assign dp = 1'b1;

    assign tens = (val >= 4'd10);
    assign ones = tens ? (val - 4'd10) : val;

    seg7_decode u_ones_dec (
        .digit   (ones),
        .pattern (ones_seg)
    );

    seg7_decode u_tens_dec (
        .digit   ({3'b000, tens}),
        .pattern (tens_seg)
    );

    // A value is accepted only after it has been seen on two consecutive samples.
    always_ff @(posedge clk) begin
        if (re) begin
            s1  <= 4'd0;
            s2  <= 4'd0;
            s3  <= 4'd0;
            val <= 4'd0;
            upd <= 1'b0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
            s3 <= s2;
            if (s2 == s3 && s2 != val) begin
                val <= s2;
                upd <= 1'b1;
            end else begin
                upd <= 1'b0;
            end
        end
    end

    assign phase_done = (state == BLANK0 || state == BLANK1) ? (pc == BLANK_LAST)
                                                             : (pc == DIG_LAST);

    always_ff @(posedge clk) begin
        if (re) begin
            state <= BLANK0;
            pc    <= '0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
        end else begin
            if (phase_done) begin
                pc <= '0;
                case (state)
                    BLANK0:  state <= DIG0;
                    DIG0:    state <= BLANK1;
                    BLANK1:  state <= DIG1;
                    default: state <= BLANK0;
                endcase
            end else begin
                pc <= pc + 1'b1;
            end

            case (state)
                DIG0: begin
                    an  <= 4'b1110;
                    seg <= ones_seg;
                end
                DIG1: begin
`ifdef CNT_SEG7_LZ_BLANK_EN
                    if (!tens) begin
                        an  <= AN_OFF;
                        seg <= SEG_OFF;
                    end else begin
                        an  <= 4'b1101;
                        seg <= tens_seg;
                    end
`else
                    an  <= 4'b1101;
                    seg <= tens_seg;
`endif
                end
                default: begin
                    an  <= AN_OFF;
                    seg <= SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_seg7_scan.sv
// Randomised self-checking bench for cnt_seg7_scan against a cycle-position
// reference model of the scan sequence and the two-sample accept rule.
module tb_cnt_seg7_scan;

    localparam int DC     = 8;
    localparam int BC     = 2;
    localparam int PERIOD = 2 * (DC + BC);

    logic       clk = 1'b0;
    logic       re;
    logic [3:0] cnt_in;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [3:0] val;
    logic       upd;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         hist [3];
    int         m_val;
    bit         m_upd;
    int         cyc;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    cnt_seg7_scan #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk    (clk),
        .re     (re),
        .cnt_in (cnt_in),
        .seg    (seg),
        .dp     (dp),
        .an     (an),
        .val    (val),
        .upd    (upd)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_pattern(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'b1000000;
            1: p = 7'b1111001;
            2: p = 7'b0100100;
            3: p = 7'b0110000;
            4: p = 7'b0011001;
            5: p = 7'b0010010;
            6: p = 7'b0000010;
            7: p = 7'b1111000;
            8: p = 7'b0000000;
            9: p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    task automatic check_output(input string tag, input logic [7:0] actual,
                                input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge with the inputs that were present before it.
    task automatic model_edge(input logic r, input logic [3:0] x);
        int prev;
        int pos;
        if (r) begin
            hist  = '{0, 0, 0};
            m_val = 0;
            m_upd = 1'b0;
            cyc   = 0;
            m_an  = 4'b1111;
            m_seg = 7'b1111111;
        end else begin
            prev = m_val;
            cyc++;
            pos = (cyc - 1) % PERIOD;
            if (pos < BC || (pos >= BC + DC && pos < 2 * BC + DC)) begin
                m_an  = 4'b1111;
                m_seg = 7'b1111111;
            end else if (pos < BC + DC) begin
                m_an  = 4'b1110;
                m_seg = digit_pattern(prev % 10);
            end else begin
                m_an  = 4'b1101;
                m_seg = digit_pattern(prev / 10);
`ifdef CNT_SEG7_LZ_BLANK_EN
                if (prev < 10) begin
                    m_an  = 4'b1111;
                    m_seg = 7'b1111111;
                end
`endif
            end
            if (hist[1] == hist[2]) m_val = hist[1];
            m_upd   = (m_val != prev);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = int'(x);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [3:0] x);
        re     = r;
        cnt_in = x;
        @(posedge clk);
        #1;
        model_edge(r, x);
        check_output("an",  {4'b0, an},  {4'b0, m_an});
        check_output("seg", {1'b0, seg}, {1'b0, m_seg});
        check_output("dp",  {7'b0, dp},  8'h01);
        check_output("val", {4'b0, val}, 8'(m_val));
        check_output("upd", {7'b0, upd}, {7'b0, m_upd});
    endtask

    task automatic hold(input logic [3:0] x, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, x);
    endtask

    initial begin
        re     = 1'b1;
        cnt_in = 4'd9;

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 4'd9);

        hold(4'd0, 5);
        hold(4'd7, 2 * PERIOD + 3);
        hold(4'd13, 2 * PERIOD + 3);

        hold(4'd4, 10);
        hold(4'd9, 1);
        hold(4'd4, 10);

        hold(4'd15, PERIOD + 5);
        hold(4'd0, PERIOD + 5);

        hold(4'd12, 5);
        while ((cyc % PERIOD) < 2 * BC + DC) apply_stimulus(1'b0, 4'd12);
        apply_stimulus(1'b1, 4'd12);
        hold(4'd12, 2 * PERIOD);

        for (int k = 0; k < 80; k++) begin
            logic [3:0] v;
            int         len;
            v   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 25);
            if ($urandom_range(0, 15) == 0) apply_stimulus(1'b1, v);
            hold(v, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
